// File: rtl/fx3_slave_fifo_model.sv
// FX3 slave-FIFO responder model: S0 (host -> GPIF read) and S1 (GPIF write -> host)
// socket buffers, delayed DMA ready flags and a fixed-latency read data path.
module fx3_slave_fifo_model #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_LATENCY  = 2,
  parameter int FLAG_LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cs_n,
  input  logic        i_oe_n,
  input  logic        i_re_n,
  input  logic        i_we_n,
  input  logic        i_pkt_end_n,
  input  logic [1:0]  i_socket_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_data_oe,
  output logic        o_in_rdy,
  output logic        o_out_rdy,
  input  logic        i_usb3_data_size_sel,
  input  logic [31:0] i_host_data,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  output logic [31:0] o_host_data,
  output logic        o_host_valid,
  output logic        o_host_last,
  input  logic        i_host_ready,
  output logic        o_underrun,
  output logic        o_overrun
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0]            FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0]            ONE_C  = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ONE_A  = ADDRESS_WIDTH'(1);

  logic [31:0]              r_s0Mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_s0Wr, r_s0Rd;
  logic [CW-1:0]            r_s0Count, w_s0CountNext;
  logic                     r_hostReady, r_underrun;

  logic [32:0]              r_s1Mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_s1Wr, r_s1Rd;
  logic [CW-1:0]            r_s1Count, w_s1CountNext;
  logic [8:0]               r_pktCnt;
  logic                     r_overrun;

  logic [31:0]              r_rdPipe [READ_LATENCY+1];
  logic                     r_dataOe;
  logic [FLAG_LATENCY-1:0]  r_inPipe, r_outPipe;

  logic        w_s0Push, w_s0Pop, w_s0Empty, w_s0PopOk;
  logic        w_s1Wr, w_s1Full, w_s1WrOk, w_s1Valid, w_s1Pop, w_last;
  logic [8:0]  w_pktLastIdx;
  logic [31:0] w_pkt, w_s1Free;
  logic [32:0] w_s1Head;

  assign w_s0Push  = i_host_valid && r_hostReady;
  assign w_s0Pop   = !i_cs_n && !i_re_n && (i_socket_addr == 2'd0);
  assign w_s0Empty = (r_s0Count == '0);
  assign w_s0PopOk = w_s0Pop && !w_s0Empty;

  assign w_s1Wr       = !i_cs_n && !i_we_n && (i_socket_addr == 2'd1);
  assign w_s1Full     = (r_s1Count == FULL_C);
  assign w_s1WrOk     = w_s1Wr && !w_s1Full;
  assign w_s1Valid    = (r_s1Count != '0);
  assign w_s1Pop      = w_s1Valid && i_host_ready;
  assign w_pktLastIdx = i_usb3_data_size_sel ? 9'd255 : 9'd127;
  assign w_last       = (r_pktCnt == w_pktLastIdx) || !i_pkt_end_n;

  assign w_pkt    = i_usb3_data_size_sel ? 32'd256 : 32'd128;
  assign w_s1Free = 32'(FULL_C - r_s1Count);
  assign w_s1Head = r_s1Mem[r_s1Rd];

  // S0 occupancy after this cycle's host push and master pop
  always_comb begin
    w_s0CountNext = r_s0Count;
    if (w_s0Push && !w_s0PopOk) w_s0CountNext = r_s0Count + ONE_C;
    else if (!w_s0Push && w_s0PopOk) w_s0CountNext = r_s0Count - ONE_C;
  end

  // S1 occupancy after this cycle's master write and host drain
  always_comb begin
    w_s1CountNext = r_s1Count;
    if (w_s1WrOk && !w_s1Pop) w_s1CountNext = r_s1Count + ONE_C;
    else if (!w_s1WrOk && w_s1Pop) w_s1CountNext = r_s1Count - ONE_C;
  end

  // S0 storage, written by the host stream
  always_ff @(posedge clk) begin
    if (w_s0Push) r_s0Mem[r_s0Wr] <= i_host_data;
  end

  // S0 pointers, count, host ready and sticky underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0Wr      <= '0;
      r_s0Rd      <= '0;
      r_s0Count   <= '0;
      r_hostReady <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_s0Push)  r_s0Wr <= r_s0Wr + ONE_A;
      if (w_s0PopOk) r_s0Rd <= r_s0Rd + ONE_A;
      r_s0Count   <= w_s0CountNext;
      r_hostReady <= (w_s0CountNext != FULL_C);
      if (w_s0Pop && w_s0Empty) r_underrun <= 1'b1;
    end
  end

  // Read data pipeline; an empty pop and idle cycles carry zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= READ_LATENCY; i++) r_rdPipe[i] <= '0;
    end else begin
      r_rdPipe[0] <= w_s0PopOk ? r_s0Mem[r_s0Rd] : 32'd0;
      for (int i = 1; i <= READ_LATENCY; i++) r_rdPipe[i] <= r_rdPipe[i-1];
    end
  end

  // Bus drive enable follows the sampled output-enable strobe by one cycle
  always_ff @(posedge clk) begin
    if (rst) r_dataOe <= 1'b0;
    else     r_dataOe <= !i_cs_n && !i_oe_n && (i_socket_addr == 2'd0);
  end

  // S1 storage: data plus end-of-packet bit
  always_ff @(posedge clk) begin
    if (w_s1WrOk) r_s1Mem[r_s1Wr] <= {w_last, i_data};
  end

  // S1 pointers, count, packet word counter and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Wr    <= '0;
      r_s1Rd    <= '0;
      r_s1Count <= '0;
      r_pktCnt  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_s1WrOk) r_s1Wr <= r_s1Wr + ONE_A;
      if (w_s1Pop)  r_s1Rd <= r_s1Rd + ONE_A;
      r_s1Count <= w_s1CountNext;
      if (w_s1Wr) begin
        r_pktCnt <= w_last ? 9'd0 : r_pktCnt + 9'd1;
        if (w_s1Full) r_overrun <= 1'b1;
      end
    end
  end

  // DMA ready flags delayed to mimic the FX3 flag latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inPipe  <= '0;
      r_outPipe <= '0;
    end else begin
      r_inPipe[0]  <= (32'(r_s0Count) >= w_pkt);
      r_outPipe[0] <= (w_s1Free >= w_pkt);
      for (int i = 1; i < FLAG_LATENCY; i++) begin
        r_inPipe[i]  <= r_inPipe[i-1];
        r_outPipe[i] <= r_outPipe[i-1];
      end
    end
  end

  assign o_data       = r_rdPipe[READ_LATENCY];
  assign o_data_oe    = r_dataOe;
  assign o_in_rdy     = r_inPipe[FLAG_LATENCY-1];
  assign o_out_rdy    = r_outPipe[FLAG_LATENCY-1];
  assign o_host_ready = r_hostReady;
  assign o_host_valid = w_s1Valid;
  assign o_host_data  = w_s1Valid ? w_s1Head[31:0] : 32'd0;
  assign o_host_last  = w_s1Valid && w_s1Head[32];
  assign o_underrun   = r_underrun;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// Scoreboard bench for fx3_slave_fifo_model: queue-based reference model of both
// sockets, read-latency scoreboard and delayed-flag history.
module tb_fx3_slave_fifo_model;

  localparam int AW    = 8;
  localparam int RL    = 2;
  localparam int FL    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csN = 1'b1, oeN = 1'b1, reN = 1'b1, weN = 1'b1, pktEndN = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] dataIn = '0;
  logic        sel = 1'b1;
  logic [31:0] hostData = '0;
  logic        hostValid = 1'b0;
  logic        hostReadyIn = 1'b0;

  logic [31:0] oData, oHostData;
  logic        oDataOe, oInRdy, oOutRdy, oHostReady, oHostValid, oHostLast;
  logic        oUnderrun, oOverrun;

  fx3_slave_fifo_model #(
    .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .FLAG_LATENCY(FL)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cs_n(csN), .i_oe_n(oeN), .i_re_n(reN), .i_we_n(weN), .i_pkt_end_n(pktEndN),
    .i_socket_addr(addr), .i_data(dataIn),
    .o_data(oData), .o_data_oe(oDataOe), .o_in_rdy(oInRdy), .o_out_rdy(oOutRdy),
    .i_usb3_data_size_sel(sel),
    .i_host_data(hostData), .i_host_valid(hostValid), .o_host_ready(oHostReady),
    .o_host_data(oHostData), .o_host_valid(oHostValid), .o_host_last(oHostLast),
    .i_host_ready(hostReadyIn),
    .o_underrun(oUnderrun), .o_overrun(oOverrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rdExp_t;

  // Reference model state
  int          cycle = 0;
  logic [31:0] s0Q[$];
  logic [32:0] s1Q[$];
  rdExp_t      rdQ[$];
  int          s1Count = 0;
  int          pktCnt = 0;
  bit          underrunM = 0, overrunM = 0, oeM = 0, readyM = 0;
  bit          accepted = 0;
  bit          rstAt [MAXC];
  bit          stage1 [2][MAXC];
  int          tests = 0, fails = 0;
  int          nextVal;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  // Flag value after edge 'cycle': the comparator captured FL-1 edges earlier,
  // unless a reset edge cleared the delay line since then.
  function automatic bit expFlag(input int which);
    int j;
    j = cycle - FL + 1;
    if (j < 1) return 1'b0;
    for (int k = j + 1; k <= cycle; k++) if (rstAt[k]) return 1'b0;
    return stage1[which][j];
  endfunction

  // Advance one clock edge and apply the specification's rules to the model
  task automatic applyStimulus();
    int          pktSize;
    bit          push, pop, wr, drain, last;
    logic [31:0] w;
    @(posedge clk);
    cycle++;
    if (cycle >= MAXC - 1) begin
      $display("[TB] FAIL cycle budget exhausted at cycle %0d", cycle);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    pktSize = sel ? 256 : 128;
    if (rst) begin
      rstAt[cycle] = 1'b1;
      stage1[0][cycle] = 1'b0;
      stage1[1][cycle] = 1'b0;
      s0Q.delete(); s1Q.delete(); rdQ.delete();
      s1Count = 0; pktCnt = 0;
      underrunM = 0; overrunM = 0; oeM = 0; readyM = 0; accepted = 0;
    end else begin
      rstAt[cycle] = 1'b0;
      stage1[0][cycle] = (s0Q.size() >= pktSize);
      stage1[1][cycle] = ((DEPTH - s1Count) >= pktSize);
      push = hostValid && readyM;
      accepted = push;
      pop = !csN && !reN && (addr == 2'd0);
      if (pop) begin
        if (s0Q.size() == 0) begin
          underrunM = 1;
          w = 32'd0;
        end else begin
          w = s0Q.pop_front();
        end
        rdQ.push_back('{due: cycle + RL, data: w});
      end
      if (push) s0Q.push_back(hostData);
      drain = (s1Count > 0) && hostReadyIn;
      wr = !csN && !weN && (addr == 2'd1);
      if (wr) begin
        last = (pktCnt == pktSize - 1) || !pktEndN;
        if (s1Count < DEPTH) begin
          s1Q.push_back({last, dataIn});
          s1Count++;
        end else begin
          overrunM = 1;
        end
        pktCnt = last ? 0 : (pktCnt + 1) % 512;
      end
      if (drain) s1Count--;
      oeM = !csN && !oeN && (addr == 2'd0);
      readyM = (s0Q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic idle(input int n);
    csN = 1; reN = 1; weN = 1; oeN = 1; pktEndN = 1; hostValid = 0;
    repeat (n) applyStimulus();
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    logic [32:0] e;
    if (cycle > 0) begin
      if (rstAt[cycle]) begin
        checkOutput("reset o_data", oData, 0);
        checkOutput("reset o_data_oe", oDataOe, 0);
        checkOutput("reset o_in_rdy", oInRdy, 0);
        checkOutput("reset o_out_rdy", oOutRdy, 0);
        checkOutput("reset o_host_ready", oHostReady, 0);
        checkOutput("reset o_host_valid", oHostValid, 0);
        checkOutput("reset o_host_last", oHostLast, 0);
        checkOutput("reset o_underrun", oUnderrun, 0);
        checkOutput("reset o_overrun", oOverrun, 0);
      end else begin
        if (rdQ.size() > 0 && rdQ[0].due == cycle) begin
          checkOutput("read data", oData, rdQ[0].data);
          void'(rdQ.pop_front());
        end
        checkOutput("o_data_oe", oDataOe, oeM);
        checkOutput("o_host_ready", oHostReady, readyM);
        checkOutput("o_underrun", oUnderrun, underrunM);
        checkOutput("o_overrun", oOverrun, overrunM);
        checkOutput("o_in_rdy", oInRdy, expFlag(0));
        checkOutput("o_out_rdy", oOutRdy, expFlag(1));
        checkOutput("o_host_valid", oHostValid, s1Count > 0);
        if (oHostValid && hostReadyIn) begin
          if (s1Q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL host word unexpected at cycle %0d: got 0x%0h, expected none", cycle, oHostData);
          end else begin
            e = s1Q.pop_front();
            checkOutput("host data", oHostData, e[31:0]);
            checkOutput("host last", oHostLast, e[32]);
          end
        end
      end
    end
  end

  initial begin
    // Reset and idle: o_host_ready after 1 cycle, o_out_rdy after FL cycles
    rst = 1; repeat (3) applyStimulus();
    rst = 0; hostReadyIn = 1; sel = 1;
    idle(6);

    // Host fills S0 with 0..255 (gappy valid), then master burst-reads it back
    nextVal = 0;
    while (nextVal < 256) begin
      hostValid = ($urandom_range(0, 3) != 0);
      hostData  = nextVal;
      applyStimulus();
      if (accepted) nextVal++;
    end
    idle(6);
    csN = 0; addr = 2'd0; oeN = 0;
    for (int i = 0; i < 256; i++) begin
      reN = 0;
      applyStimulus();
    end
    reN = 1; applyStimulus();
    idle(8);

    // 128-word packet into S1 with sel=0, host drains with random backpressure
    sel = 0;
    csN = 0; addr = 2'd1;
    for (int i = 0; i < 128; i++) begin
      weN = 0;
      dataIn = $urandom;
      hostReadyIn = $urandom_range(0, 1);
      applyStimulus();
    end
    hostReadyIn = 1;
    idle(140);

    // Short packets terminated by pkt_end: 5 words, then 3 words
    csN = 0; addr = 2'd1;
    for (int i = 1; i <= 5; i++) begin
      weN = 0; pktEndN = (i == 5) ? 1'b0 : 1'b1;
      dataIn = 32'hC000_0000 + i;
      applyStimulus();
    end
    for (int i = 1; i <= 3; i++) begin
      weN = 0; pktEndN = (i == 3) ? 1'b0 : 1'b1;
      dataIn = 32'hD000_0000 + i;
      applyStimulus();
    end
    idle(10);

    // Single read of empty S0
    csN = 0; addr = 2'd0; reN = 0; oeN = 0;
    applyStimulus();
    idle(6);

    // Randomised mixed traffic, including ignored socket addresses
    sel = $urandom_range(0, 1);
    for (int i = 0; i < 800; i++) begin
      hostValid   = $urandom_range(0, 2) != 0;
      hostData    = $urandom;
      hostReadyIn = $urandom_range(0, 1);
      csN         = ($urandom_range(0, 3) == 0);
      addr        = 2'($urandom_range(0, 3));
      reN         = $urandom_range(0, 1);
      weN         = $urandom_range(0, 1);
      oeN         = $urandom_range(0, 1);
      pktEndN     = ($urandom_range(0, 7) != 0);
      dataIn      = $urandom;
      applyStimulus();
    end
    hostReadyIn = 1;
    idle(300);

    // Fill S1 to depth with host stalled, then one extra write
    hostReadyIn = 0;
    csN = 0; addr = 2'd1;
    for (int i = 0; i <= DEPTH; i++) begin
      weN = 0; dataIn = $urandom;
      applyStimulus();
    end
    idle(6);
    hostReadyIn = 1;
    idle(280);

    // Reset in the middle of concurrent reads and writes
    for (int i = 0; i < 40; i++) begin
      hostValid = 1; hostData = $urandom;
      csN = 0; addr = 2'd1; weN = 0; dataIn = $urandom;
      applyStimulus();
    end
    weN = 1; addr = 2'd0; reN = 0; oeN = 0;
    for (int i = 0; i < 10; i++) begin
      hostData = $urandom;
      applyStimulus();
    end
    rst = 1; applyStimulus();
    rst = 0;
    idle(FL + 4);

    checkOutput("pending read words", rdQ.size(), 0);
    checkOutput("pending host words", s1Q.size(), 0);
    checkOutput("model S0 empty after reset", s0Q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fx3_slave_fifo_model.md
# fx3_slave_fifo_model

Synthesizable model of the FX3 side of the GPIF II slave-FIFO interface: the responder that our FPGA-side GPIF master talks to. It holds two socket buffers, one FX3-to-FPGA and one FPGA-to-FX3, and drives the DMA ready flags and the read data bus with configurable latencies. The host side of each buffer is a valid/ready stream. It sits in loopback test builds and simulation benches in place of the physical FX3.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, log2 of each socket buffer depth in 32-bit words.
- READ_LATENCY, 2, cycles from sampled read strobe to valid `o_data`; minimum 1.
- FLAG_LATENCY, 3, pipeline stages on `o_in_rdy`/`o_out_rdy`; minimum 1.

Ports:
- clk  in  1  single clock, also the GPIF clock.
- rst  in  1  synchronous, active-high reset.
- i_cs_n, i_oe_n, i_re_n, i_we_n, i_pkt_end_n  in  1 each  GPIF strobes from master, active low.
- i_socket_addr  in  2  0 = FX3-to-FPGA socket (S0), 1 = FPGA-to-FX3 socket (S1); 2 and 3 are ignored.
- i_data  in  32  write data from master.
- o_data  out  32  read data to master.
- o_data_oe  out  1  model drives the data bus.
- o_in_rdy  out  1  S0 holds a full packet.
- o_out_rdy  out  1  S1 has space for a full packet.
- i_usb3_data_size_sel  in  1  packet size: 1 = 256 words, 0 = 128 words.
- i_host_data  in  32, i_host_valid  in  1, o_host_ready  out  1  host fill of S0.
- o_host_data  out  32, o_host_valid  out  1, o_host_last  out  1, i_host_ready  in  1  host drain of S1.
- o_underrun, o_overrun  out  1 each  sticky error flags, cleared only by reset.

## Operation
- PKT = 256 or 128, selected by `i_usb3_data_size_sel`. Each buffer has a count register of ADDRESS_WIDTH+1 bits. If the depth is smaller than PKT, the related flag never asserts.
- S0 fill: a host push is accepted when `i_host_valid && o_host_ready`. `o_host_ready` is registered and equals "S0 not full".
- S0 read: a pop occurs in every cycle where `!i_cs_n && !i_re_n && i_socket_addr==0`. A pop happens regardless of `i_oe_n`.
  - The popped word reaches `o_data` through a READ_LATENCY-deep pipeline.
  - A pop from an empty buffer returns 0, sets `o_underrun`, and leaves the count unchanged.
- `o_data_oe` is registered. It asserts the cycle after `!i_cs_n && !i_oe_n && i_socket_addr==0` is sampled and deasserts the cycle after that condition drops.
- S1 write: a write occurs in every cycle where `!i_cs_n && !i_we_n && i_socket_addr==1`. The stored entry is 33 bits: data plus a last bit.
  - A 9-bit packet word counter increments on each write.
  - last = 1 when the counter reaches PKT-1, or when `!i_pkt_end_n` is sampled in the same cycle.
  - The counter clears after any last word.
  - A write while S1 is full is dropped, sets `o_overrun`, and still advances the packet counter.
- `i_pkt_end_n` low without `i_we_n` low (zero-length packet) is ignored.
- S1 drain: `o_host_valid` = S1 not empty. The head word and its last bit appear on `o_host_data`/`o_host_last`. The word pops on `o_host_valid && i_host_ready`.
- Flags:
  - `o_in_rdy` = (S0 count >= PKT) passed through FLAG_LATENCY registers.
  - `o_out_rdy` = (S1 free >= PKT) passed through FLAG_LATENCY registers.
- Simultaneous push and pop on the same buffer leaves the count unchanged and loses no data.
- Buffers wrap at 2^ADDRESS_WIDTH.

## Timing
- Reset values: `o_data` 0, `o_data_oe` 0, `o_in_rdy` 0, `o_out_rdy` 0, `o_host_ready` 0, `o_host_valid` 0, `o_host_last` 0, error flags 0. Buffers are emptied, pipelines cleared, packet counter 0.
- After reset release:
  - `o_host_ready` = 1 after 1 cycle.
  - `o_out_rdy` = 1 after FLAG_LATENCY cycles, if depth >= PKT.
- Reset asserted mid-burst discards all buffered data and in-flight read pipeline words in the same cycle.
- Read: pop sampled at edge N; data on `o_data` after edge N+READ_LATENCY. Back-to-back pops give one word per cycle.
- Flag response: a count change at edge N is reflected on the flag at edge N+FLAG_LATENCY. The master therefore may over-read, which sets `o_underrun`; this is intended behaviour.

## Test plan
- Host pushes 256 words 0..255, sel=1 -> `o_in_rdy` rises 3 cycles after the 256th push. Master burst read returns 0..255 on `o_data`, each word 2 cycles after its `i_re_n` cycle; `o_in_rdy` falls 3 cycles after the count drops below 256.
- sel=0, master writes 128 words to S1 -> host stream delivers 128 words with `o_host_last` only on word 127.
- Master writes 5 words with `i_pkt_end_n` low on word 5 -> host sees 5 words, last on word 5. The next packet's counter starts from 0.
- S0 empty, master asserts re for 1 cycle -> `o_data` = 0 after 2 cycles; `o_underrun` = 1 and stays 1.
- S1 filled to depth, `i_host_ready` = 0, one more write -> word dropped, `o_overrun` = 1, `o_out_rdy` = 0.
- Reset asserted mid-read and mid-write -> all outputs at their reset values next cycle; S0/S1 empty; `o_out_rdy` = 1 three cycles after release.
